// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 I/D cache to physical-memory arbiter.
package arbiter_types;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        src_icache = 1'b0,
        src_dcache = 1'b1
    } grant_src_t;

    typedef enum logic {
        op_read  = 1'b0,
        op_write = 1'b1
    } op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline adapter port between the I-cache and D-cache.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter bit          D_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam grant_src_t RESET_PRIO = D_FIRST ? src_dcache : src_icache;

    state_t            state, state_next;
    grant_src_t        prio, prio_next;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              read_q, write_q;
    logic [CNT_W-1:0]  num_i_grants, num_d_grants, num_conflicts;

    logic              i_req, d_req, conflict, grant;
    grant_src_t        grant_src;
    op_t               grant_op;
    logic [ADDR_W-1:0] grant_addr;
    logic [LINE_W-1:0] grant_wdata;

    assign i_req    = i_pmem_read;
    assign d_req    = d_pmem_read | d_pmem_write;
    assign conflict = (state == IDLE) && i_req && d_req;

    // Next-state, grant selection and priority rotation
    always_comb begin
        state_next  = state;
        prio_next   = prio;
        grant       = 1'b0;
        grant_src   = src_icache;
        grant_op    = op_read;
        grant_addr  = i_pmem_address;
        grant_wdata = '0;
        unique case (state)
            IDLE: begin
                if (d_req && (!i_req || prio == src_dcache)) begin
                    grant       = 1'b1;
                    grant_src   = src_dcache;
                    // A simultaneous read+write is illegal; the write wins.
                    grant_op    = d_pmem_write ? op_write : op_read;
                    grant_addr  = d_pmem_address;
                    grant_wdata = d_pmem_wdata;
                    state_next  = SERVE_D;
                end else if (i_req) begin
                    grant      = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_next = IDLE;
                    prio_next  = src_dcache;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_next = IDLE;
                    prio_next  = src_icache;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched request and perf counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            prio          <= RESET_PRIO;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            num_i_grants  <= '0;
            num_d_grants  <= '0;
            num_conflicts <= '0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            if (grant) begin
                addr_q  <= grant_addr;
                wdata_q <= grant_wdata;
                read_q  <= (grant_op == op_read);
                write_q <= (grant_op == op_write);
                if (grant_src == src_dcache) num_d_grants <= num_d_grants + CNT_W'(1);
                else                         num_i_grants <= num_i_grants + CNT_W'(1);
            end else if (state != IDLE && mem_resp) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
            end
            if (conflict) num_conflicts <= num_conflicts + CNT_W'(1);
        end
    end

    assign mem_read     = read_q;
    assign mem_write    = write_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;
    // Completion is passed straight through to the side currently being served.
    assign i_pmem_resp  = mem_resp && (state == SERVE_I);
    assign d_pmem_resp  = mem_resp && (state == SERVE_D);

    // The D-cache must never ask for a read and a writeback at once
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

endmodule
